// File: rtl/bit_reverse_stream_buffer.sv
// bit_reverse_stream_buffer: ping-pong frame buffer that emits each frame in bit-reversed or natural order
module bit_reverse_stream_buffer #(
    parameter int LOG2N = 3,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             rev_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
);
    localparam int size = 1 << LOG2N;
    localparam logic [LOG2N-1:0] last_cnt = '1;
    logic [DW-1:0] mem [2*size];
    logic [1:0] full, mode;
    logic wr_bank, rd_bank, wr_fire, rd_fire;
    logic [LOG2N-1:0] wr_cnt, rd_cnt, rev_cnt, addr;
    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign rev_cnt[i] = rd_cnt[LOG2N-1-i];
    end
    assign in_ready  = !rst && !full[wr_bank];
    assign out_valid = !rst && full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign addr      = mode[rd_bank] ? rev_cnt : rd_cnt;
    assign out_data  = out_valid ? mem[{rd_bank, addr}] : '0;
    assign out_index = out_valid ? addr : '0;
    assign out_last  = out_valid && rd_cnt == last_cnt;
    always_ff @(posedge clk)
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= in_data;
    // a FULL set and an EMPTY clear always hit different banks, so both bit writes stand
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            mode    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == '0) mode[wr_bank] <= rev_en;
                if (wr_cnt == last_cnt) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == last_cnt) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end
endmodule
